// File: rtl/rotator_arbiter_pkg.sv
// Shared helpers for the rotator arbiter and its sub-blocks.
package rotator_arbiter_pkg;

  // Ceiling log2; the width needed to hold values 0..v-1.
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rotator.sv
// Combinational barrel rotator; DIR = 0 rotates left, DIR = 1 rotates right.
// The amount must be below N.
module rotator #(
  parameter int unsigned N   = 8,
  parameter int unsigned L   = 3,
  parameter bit          DIR = 1'b0
) (
  input  logic [N-1:0] data_i,
  input  logic [L-1:0] amt_i,
  output logic [N-1:0] data_o
);

  logic [2*N-1:0] dbl;

  generate
    if (DIR == 1'b0) begin : g_left
      // Shift the doubled word left; the upper half is the rotated word.
      always_comb begin
        dbl    = {data_i, data_i} << amt_i;
        data_o = dbl[2*N-1:N];
      end
    end else begin : g_right
      // Shift the doubled word right; the lower half is the rotated word.
      always_comb begin
        dbl    = {data_i, data_i} >> amt_i;
        data_o = dbl[N-1:0];
      end
    end
  endgenerate

endmodule

// File: rtl/rotator_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr, ptr moves
// past the winner only when the grant is enabled and taken.
module rr_arbiter
  import rotator_arbiter_pkg::*;
#(
  parameter int unsigned R = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [R-1:0] req,
  input  logic         en,
  output logic [R-1:0] gnt
);

  localparam int unsigned RI = log2c(R);

  logic [RI-1:0] ptr_q;
  logic [RI-1:0] ptr_d;
  logic          found;
  int unsigned   idx;

  // Search req from ptr upward, wrapping at R; first hit wins.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < R; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= R) idx = idx - R;
      if (!found && req[RI'(idx)]) begin
        found          = 1'b1;
        gnt[RI'(idx)]  = 1'b1;
        ptr_d          = (idx + 1 == R) ? '0 : RI'(idx + 1);
      end
    end
    if (!en) begin
      gnt   = '0;
      ptr_d = ptr_q;
    end
  end

  // Priority pointer; advances only on a taken grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en && (|gnt)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rotator_arbiter.sv
// Shares one left rotator between R requesters: round-robin grant, amount
// normalisation, and a one-deep valid/ready result register.
module rotator_arbiter
  import rotator_arbiter_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4,
  localparam int unsigned L  = log2c(N),
  localparam int unsigned RI = log2c(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   in_valid,
  output logic [R-1:0]   in_ready,
  input  logic [R*N-1:0] in_data,
  input  logic [R*L-1:0] in_rot,
  input  logic [R-1:0]   in_dir,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [RI-1:0]  out_id
);

  localparam int unsigned LW  = L + 1;
  localparam logic [L:0]  N_X = LW'(N);

  logic [R-1:0]  gnt;
  logic          en;
  logic [N-1:0]  sel_data;
  logic [L-1:0]  sel_rot;
  logic          sel_dir;
  logic [RI-1:0] sel_id;
  logic [L:0]    rot_x;
  logic [L:0]    k_x;
  logic [L:0]    amt_x;
  logic [L-1:0]  amt;
  logic [N-1:0]  rot_data;

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q,  out_data_d;
  logic [RI-1:0] out_id_q,    out_id_d;

  // Grant only when the result slot is free and not in reset.
  assign en       = ~rst & (~out_valid_q | out_ready);
  assign in_ready = gnt;

  rr_arbiter #(.R(R)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (in_valid),
    .en  (en),
    .gnt (gnt)
  );

  // One-hot select of the granted requester's fields.
  always_comb begin
    sel_data = '0;
    sel_rot  = '0;
    sel_dir  = 1'b0;
    sel_id   = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (gnt[i]) begin
        sel_data = sel_data | in_data[i*N +: N];
        sel_rot  = sel_rot  | in_rot[i*L +: L];
        sel_dir  = sel_dir  | in_dir[i];
        sel_id   = RI'(i);
      end
    end
  end

  // Fold rot into 0..N-1, then turn a right rotate into the equivalent left one.
  always_comb begin
    rot_x = {1'b0, sel_rot};
    k_x   = (rot_x >= N_X) ? (rot_x - N_X) : rot_x;
    amt_x = (sel_dir && (k_x != '0)) ? (N_X - k_x) : k_x;
    amt   = amt_x[L-1:0];
  end

  rotator #(.N(N), .L(L), .DIR(1'b0)) u_rot (
    .data_i (sel_data),
    .amt_i  (amt),
    .data_o (rot_data)
  );

  // Result register next state: load on grant, drain on output transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (|gnt) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_data;
      out_id_d    = sel_id;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rotator_arbiter.sv
// Bench for rotator_arbiter: an N=8/R=4 instance and an N=6/R=2 instance
// driven side by side, checked against a per-cycle behavioural model.
module tb_rotator_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: N=8, R=4, L=3, RI=2
  logic [3:0]  a_v, a_rdy, a_dir;
  logic [31:0] a_d;
  logic [11:0] a_r;
  logic        a_ordy, a_ov;
  logic [7:0]  a_od;
  logic [1:0]  a_oid;

  // Instance B: N=6, R=2, L=3, RI=1
  logic [1:0]  b_v, b_rdy, b_dir;
  logic [11:0] b_d;
  logic [5:0]  b_r;
  logic        b_ordy, b_ov;
  logic [5:0]  b_od;
  logic [0:0]  b_oid;

  rotator_arbiter #(.N(8), .R(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_v), .in_ready(a_rdy), .in_data(a_d),
    .in_rot(a_r), .in_dir(a_dir), .out_valid(a_ov), .out_ready(a_ordy),
    .out_data(a_od), .out_id(a_oid)
  );

  rotator_arbiter #(.N(6), .R(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_v), .in_ready(b_rdy), .in_data(b_d),
    .in_rot(b_r), .in_dir(b_dir), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .out_id(b_oid)
  );

  int vec  = 0;
  int errs = 0;

  // Reference state per instance (0 = A, 1 = B)
  int m_ptr [2];
  int m_ov  [2];
  int m_od  [2];
  int m_oid [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rotate bit by bit: left moves bit j to (j+k) mod n, right to (j-k) mod n.
  function automatic int rot_ref(input int data, input int rot, input int dir, input int n);
    int k, res, dst;
    k   = rot % n;
    res = 0;
    for (int j = 0; j < n; j++) begin
      dst = (dir != 0) ? ((j - k + n) % n) : ((j + k) % n);
      if (((data >> j) & 1) != 0) res = res | (1 << dst);
    end
    return res;
  endfunction

  // One clock: check grants, clock, update model, check result register.
  task automatic cycle();
    int n, r, g, v, ordy, dirs, nptr, nv, nd, nid, i;
    logic [31:0] dall, rall;
    int erdy [2];
    int pv [2], pd [2], pid [2], pptr [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      n    = (d == 0) ? 8 : 6;
      r    = (d == 0) ? 4 : 2;
      v    = (d == 0) ? int'(a_v)   : int'(b_v);
      dirs = (d == 0) ? int'(a_dir) : int'(b_dir);
      ordy = (d == 0) ? int'(a_ordy) : int'(b_ordy);
      dall = (d == 0) ? a_d : {20'b0, b_d};
      rall = (d == 0) ? {20'b0, a_r} : {26'b0, b_r};
      g = -1;
      if (rst == 1'b0 && (m_ov[d] == 0 || ordy != 0)) begin
        for (int o = 0; o < r; o++) begin
          i = (m_ptr[d] + o) % r;
          if (g < 0 && ((v >> i) & 1) != 0) g = i;
        end
      end
      erdy[d] = (g < 0) ? 0 : (1 << g);
      nptr = m_ptr[d]; nv = m_ov[d]; nd = m_od[d]; nid = m_oid[d];
      if (rst) begin
        nptr = 0; nv = 0; nd = 0; nid = 0;
      end else if (g >= 0) begin
        nd   = rot_ref(int'((dall >> (g * n)) & ((32'd1 << n) - 1)),
                       int'((rall >> (g * 3)) & 32'd7), (dirs >> g) & 1, n);
        nid  = g;
        nv   = 1;
        nptr = (g + 1) % r;
      end else if (ordy != 0) begin
        nv = 0;
      end
      pv[d] = nv; pd[d] = nd; pid[d] = nid; pptr[d] = nptr;
    end
    chk("a_in_ready", 32'(a_rdy), 32'(erdy[0]));
    chk("b_in_ready", 32'(b_rdy), 32'(erdy[1]));
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = pv[d]; m_od[d] = pd[d]; m_oid[d] = pid[d]; m_ptr[d] = pptr[d];
    end
    #1;
    chk("a_out_valid", 32'(a_ov),  32'(m_ov[0]));
    chk("a_out_data",  32'(a_od),  32'(m_od[0]));
    chk("a_out_id",    32'(a_oid), 32'(m_oid[0]));
    chk("b_out_valid", 32'(b_ov),  32'(m_ov[1]));
    chk("b_out_data",  32'(b_od),  32'(m_od[1]));
    chk("b_out_id",    32'(b_oid), 32'(m_oid[1]));
  endtask

  int saved_id;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_ov[d] = 0; m_od[d] = 0; m_oid[d] = 0;
    end
    rst = 1'b1;
    a_v = '0; a_d = '0; a_r = '0; a_dir = '0; a_ordy = 1'b1;
    b_v = '0; b_d = '0; b_r = '0; b_dir = '0; b_ordy = 1'b1;
    @(posedge clk);
    #1;
    a_v = 4'hF;
    cycle();
    cycle();
    chk("reset_out_valid", 32'(a_ov), 32'd0);
    a_v = '0;
    rst = 1'b0;
    #1;

    // Basic left / right on requester 2; N=6 non-power-of-two on requester 0
    a_v = 4'b0100; a_d = 32'h0001_0000; a_r = 12'(3 << 6); a_dir = 4'b0000;
    b_v = 2'b01;   b_d = 12'h001;       b_r = 6'd7;        b_dir = 2'b00;
    cycle();
    chk("basic_left_data", 32'(a_od), 32'h08);
    chk("basic_left_id",   32'(a_oid), 32'd2);
    chk("n6_rot7_left",    32'(b_od), 32'h02);
    a_dir = 4'b0100; b_dir = 2'b01;
    cycle();
    chk("basic_right_data", 32'(a_od), 32'h20);
    chk("n6_rot7_right",    32'(b_od), 32'h20);
    a_d = 32'h00A5_0000; a_r = '0; b_r = 6'd6; b_dir = 2'b00;
    cycle();
    chk("zero_rot_right", 32'(a_od), 32'hA5);
    chk("n6_rot6_left",   32'(b_od), 32'h01);
    b_dir = 2'b01;
    cycle();
    chk("n6_rot6_right",  32'(b_od), 32'h01);
    a_v = '0; b_v = '0;
    cycle();

    // Round robin from reset with all valid
    rst = 1'b1; a_v = 4'hF; a_d = 32'h8040_2010; a_r = 12'h1A5;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_all_id", 32'(a_oid), 32'(k % 4));
    end

    // Only requesters 1 and 3
    rst = 1'b1;
    cycle();
    rst = 1'b0; a_v = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_13_id", 32'(a_oid), 32'((k % 2 == 0) ? 1 : 3));
    end

    // Backpressure for 3 cycles after a result
    a_v = 4'hF;
    cycle();
    saved_id = m_oid[0];
    a_ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_id", 32'(a_oid), 32'(saved_id));
      chk("stall_rdy", 32'(a_rdy), 32'd0);
    end
    a_ordy = 1'b1;
    cycle();
    chk("release_id", 32'(a_oid), 32'((saved_id + 1) % 4));

    // Reset while a result is stalled
    a_ordy = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_valid", 32'(a_ov), 32'd0);
    chk("midrst_data",  32'(a_od), 32'd0);
    rst = 1'b0; a_ordy = 1'b1; a_v = 4'hF;
    cycle();
    chk("postrst_id", 32'(a_oid), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      a_v    = 4'($urandom);  a_d = $urandom; a_r = 12'($urandom); a_dir = 4'($urandom);
      a_ordy = ($urandom_range(0, 3) != 0);
      b_v    = 2'($urandom);  b_d = 12'($urandom); b_r = 6'($urandom); b_dir = 2'($urandom);
      b_ordy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/rotator_arbiter.md
# rotator_arbiter

Shares one combinational rotator between R requesters, so that several clause or literal-vector producers in the solver can use a single barrel rotator instead of each instantiating its own. Each cycle it grants at most one request in round-robin order and normalises the rotate amount and direction. It rotates the granted word and holds the result in a one-deep output register with a valid/ready handshake toward the consumer.

## Interface
- N, 8: data width in bits; any N ≥ 2, not required to be a power of two.
- R, 4: number of requesters; R ≥ 2.
- L (local, derived): log2c(N), the rotate-amount width.
- RI (local, derived): log2c(R), the requester-id width.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  R  per-requester request valid.
- in_ready  output  R  per-requester grant; one-hot or zero.
- in_data  input  R*N  requester i's word is in_data[i*N +: N].
- in_rot  input  R*L  requester i's rotate amount is in_rot[i*L +: L].
- in_dir  input  R  per-requester direction: 0 rotates left, 1 rotates right.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  rotated word.
- out_id  output  RI  index of the requester that produced out_data.

## Operation
- Transfers:
  - Input transfer: in_valid[i] & in_ready[i] in the same cycle.
  - Output transfer: out_valid & out_ready in the same cycle.
- Slot free condition: free = ~out_valid | out_ready.
- Grant:
  - If free, in_ready is the one-hot round-robin pick among the asserted in_valid bits.
  - Otherwise in_ready = 0.
  - in_ready depends combinationally on in_valid and out_ready. A requester must not make in_valid depend on in_ready.
- Round-robin pointer ptr:
  - ptr has range 0..R-1 and names the highest-priority requester.
  - Search order is ptr, ptr+1, …, wrapping modulo R.
  - After granting requester g, ptr becomes (g+1) mod R.
  - With no grant, ptr is unchanged.
- Amount normalisation:
  - Reduce the amount: k = rot ≥ N ? rot − N : rot. This is exact because rot < 2^L < 2N.
  - For a left rotate, amount = k.
  - For a right rotate, amount = (k == 0) ? 0 : N − k.
  - The shared rotator runs left-only (DIR = 0) and receives the normalised amount.
  - All arithmetic is done at L+1 bits and truncated to L bits.
- Output register:
  - On a grant, load out_data = the rotated word and out_id = g, and set out_valid = 1.
  - On an output transfer with no new grant, clear out_valid. out_data and out_id hold their stale values.
  - A simultaneous output transfer and grant reloads the register, so out_valid stays 1 and one result per cycle is sustained.
- Stall: with out_valid = 1 and out_ready = 0, out_data and out_id are held stable and all in_ready bits are 0.
- Reset behaviour:
  - Reset values: out_valid = 0, out_data = 0, out_id = 0, ptr = 0.
  - A result pending at reset is discarded.
  - in_ready is 0 during reset.

## Timing
- Latency: an input transfer in cycle t gives out_valid = 1 in cycle t+1.
- Throughput: one request per cycle while out_ready = 1.
- The combinational path is arbiter, then normalisation, then rotator, then register. There is no path from in_data to out_data within a single cycle.
- There is no combinational path from out_ready to out_valid or out_data.

## Structure
- log2c lives in the shared math include; this block has no other shared constants or typedefs.
- Sub-module rr_arbiter, with parameter R, ports clk, rst, req[R], en, and output gnt[R] one-hot:
  - It owns ptr.
  - It advances ptr only when en is high and gnt is non-zero.
  - It is reusable by other shared-resource blocks.
- The top level contains:
  - the rr_arbiter instance;
  - a one-hot mux for in_data, in_rot and in_dir;
  - the normalisation logic;
  - one instance of the existing rotator module with DIR = 0;
  - the output register.

## Test plan
- Basic left and right (N=8, R=4, out_ready=1):
  - Requester 2 sends data 8'h01, rot 3, dir 0 → next cycle out_data = 8'h08, out_id = 2.
  - Then data 8'h01, rot 3, dir 1 → out_data = 8'h20.
- Zero rotate, right (N=8): data 8'hA5, rot 0, dir 1 → out_data = 8'hA5.
- Non-power-of-two N (N=6, L=3):
  - data 6'b000001, rot 7, dir 0 → 6'b000010.
  - Same data, rot 7, dir 1 → 6'b100000.
  - rot 6, either direction → data unchanged.
- Round robin (N=8, R=4):
  - All four in_valid held high from reset, out_ready=1 → out_id sequence 0,1,2,3,0,1, one result per cycle.
  - Only requesters 1 and 3 valid → out_id sequence 1,3,1,3.
- Backpressure: with all valid, drop out_ready for 3 cycles after the first result → out_data and out_id stay stable, in_ready = 0 throughout; on release, the next grant goes to (previous id + 1) mod R.
- Reset mid-operation: assert rst while out_valid = 1 and out_ready = 0 → next cycle out_valid = 0 and out_data = 0; the first grant after reset goes to requester 0 when all are valid.
